mem_responder: RTL and testbench

Word-addressed, byte-enabled memory responder that sits on the far side of the core's `mem_read`/`mem_write`/`mem_resp` memory port. It accepts one request at a time, waits a programmable number of cycles, then completes it with a one-cycle `mem_resp` pulse, returning read data or committing write bytes to internal storage. It serves as the synthesizable backing store and latency model for the multicycle core in integration builds.

---
 rtl/mem_responder.sv | 152 +++++++++++++++
 tb/tb_mem_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder -- word-addressed, byte-enabled memory responder.
//
// Accepts one mem_read/mem_write request at a time, waits LATENCY cycles,
// then completes it with a single-cycle mem_resp pulse. A read returns
// registered data in the response cycle. A write commits its enabled bytes
// at the end of the response cycle. Storage is not cleared by reset.
//
// Parameters:
//   ADDR_WIDTH  word-index width; storage holds 2**ADDR_WIDTH 32-bit words
//   LATENCY     request acceptance to mem_resp, in cycles (legal 1..15)
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   mem_read         read request, held until mem_resp is sampled
//   mem_write        write request, held the same way (wins over mem_read)
//   mem_byte_enable  per-byte write mask
//   mem_address      byte address; bits [ADDR_WIDTH+1:2] index storage
//   mem_wdata        write data
//   mem_resp         one-cycle completion pulse
//   mem_rdata        read data, valid in the mem_resp cycle of a read
//   proto_err        sticky protocol-violation flag (only when
//                    MEM_RESPONDER_CHECK_EN is defined)
//
// Build option: define MEM_RESPONDER_CHECK_EN to add the protocol checker
// and its proto_err port.

module mem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic        mem_resp,
  output logic [31:0] mem_rdata
`ifdef MEM_RESPONDER_CHECK_EN
  ,
  output logic        proto_err
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Counter preload so that WAIT lasts LATENCY-1 cycles before RESP.
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : '0;

  state_t                state_q;
  logic [3:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [31:0]           wdata_q;
  logic [3:0]            be_q;
  logic                  wr_q;
  logic [31:0]           mem_q [2**ADDR_WIDTH];

  logic                  req;
  logic [ADDR_WIDTH-1:0] req_idx;
  logic                  addr_unused;

  assign req         = mem_read | mem_write;
  assign req_idx     = mem_address[ADDR_WIDTH+1:2];
  // Byte offset and alias bits above the index are deliberately ignored.
  assign addr_unused = ^{mem_address[31:ADDR_WIDTH+2], mem_address[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mem_resp  <= 1'b0;
      mem_rdata <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          mem_resp <= 1'b0;
          if (req) begin
            idx_q   <= req_idx;
            wdata_q <= mem_wdata;
            be_q    <= mem_byte_enable;
            wr_q    <= mem_write;
            if (LATENCY == 1) begin
              // No WAIT cycle: read storage with the incoming index.
              state_q  <= RESP;
              mem_resp <= 1'b1;
              if (!mem_write) mem_rdata <= mem_q[req_idx];
            end else begin
              cnt_q   <= CNT_INIT;
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q  <= RESP;
            mem_resp <= 1'b1;
            if (!wr_q) mem_rdata <= mem_q[idx_q];
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          state_q  <= IDLE;
          mem_resp <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          mem_resp <= 1'b0;
        end
      endcase
    end
  end

  // Write commit at the end of RESP; a reset in that cycle suppresses it.
  always_ff @(posedge clk) begin
    if (!rst && state_q == RESP && wr_q) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be_q[i]) mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

`ifdef MEM_RESPONDER_CHECK_EN
  logic rst_q;
  logic viol;

  always_comb begin
    viol = 1'b0;
    if (mem_read && mem_write) viol = 1'b1;
    if (state_q != IDLE && (!req || req_idx != idx_q || mem_write != wr_q))
      viol = 1'b1;
    // Parameter legality is evaluated on the first cycle out of reset.
    if (rst_q && (LATENCY < 1 || LATENCY > 15)) viol = 1'b1;
  end

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      proto_err <= 1'b0;
    end else if (viol) begin
      proto_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic        rd  [3];
  logic        wr  [3];
  logic [3:0]  be  [3];
  logic [31:0] ad  [3];
  logic [31:0] wd  [3];
  logic        rsp [3];
  logic [31:0] rdt [3];
  logic        perr[3];

  // Reference model: plain word arrays per instance.
  logic [31:0] mdl    [3][1024];
  bit          vld    [3][1024];
  logic [31:0] last_rd[3];
  int          n_vec;
  int          n_err;
  int          cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst), .mem_read(rd[0]), .mem_write(wr[0]),
    .mem_byte_enable(be[0]), .mem_address(ad[0]), .mem_wdata(wd[0]),
    .mem_resp(rsp[0]), .mem_rdata(rdt[0])
`ifdef MEM_RESPONDER_CHECK_EN
    , .proto_err(perr[0])
`endif
  );

  mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .mem_read(rd[1]), .mem_write(wr[1]),
    .mem_byte_enable(be[1]), .mem_address(ad[1]), .mem_wdata(wd[1]),
    .mem_resp(rsp[1]), .mem_rdata(rdt[1])
`ifdef MEM_RESPONDER_CHECK_EN
    , .proto_err(perr[1])
`endif
  );

  mem_responder #(.ADDR_WIDTH(10), .LATENCY(15)) u_lat15 (
    .clk(clk), .rst(rst), .mem_read(rd[2]), .mem_write(wr[2]),
    .mem_byte_enable(be[2]), .mem_address(ad[2]), .mem_wdata(wd[2]),
    .mem_resp(rsp[2]), .mem_rdata(rdt[2])
`ifdef MEM_RESPONDER_CHECK_EN
    , .proto_err(perr[2])
`endif
  );

  function automatic int lat_of(input int d);
    case (d)
      0:       return 2;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Issue one request in the current IDLE cycle, wait for mem_resp, check
  // latency/data/pulse width. Returns in the following IDLE cycle.
  task automatic txn(input int d, input bit w, input logic [31:0] a, input logic [3:0] b,
                     input logic [31:0] dat, input bit hold, output int rc);
    int n;
    int idx;
    idx   = int'(a[11:2]);
    rd[d] = !w;
    wr[d] = w;
    ad[d] = a;
    be[d] = b;
    wd[d] = dat;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!rsp[d] && n < 40);
    rc = cyc;
    check($sformatf("latency[%0d]", d), 32'(n), 32'(lat_of(d)));
    if (!w) begin
      check($sformatf("rdata[%0d] @%h", d, a), rdt[d], mdl[d][idx]);
      last_rd[d] = mdl[d][idx];
    end else begin
      check($sformatf("wr_rdata_unchanged[%0d]", d), rdt[d], last_rd[d]);
      for (int i = 0; i < 4; i++)
        if (b[i]) mdl[d][idx][8*i +: 8] = dat[8*i +: 8];
      vld[d][idx] = 1'b1;
    end
    @(posedge clk); #1;
    check($sformatf("pulse[%0d]", d), 32'(rsp[d]), 32'd0);
    check($sformatf("rdata_hold[%0d]", d), rdt[d], last_rd[d]);
    if (!hold) begin
      rd[d] = 1'b0;
      wr[d] = 1'b0;
    end
  endtask

  // Start a write on instance 0, then assert reset after `at_n` edges.
  task automatic reset_abort(input logic [31:0] a, input logic [31:0] dat, input int at_n);
    rd[0] = 1'b0;
    wr[0] = 1'b1;
    ad[0] = a;
    be[0] = 4'hF;
    wd[0] = dat;
    repeat (at_n) begin
      @(posedge clk); #1;
    end
    check("resp_before_rst", 32'(rsp[0]), (at_n == 2) ? 32'd1 : 32'd0);
    rst   = 1'b1;
    wr[0] = 1'b0;
    @(posedge clk); #1;
    check("resp_in_rst", 32'(rsp[0]), 32'd0);
    check("rdata_in_rst", rdt[0], 32'd0);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) last_rd[d] = '0;
  endtask

  initial begin
    int rc0, rc1, rc2, idx;
    bit w;
    logic [31:0] a;
    logic [3:0] b;
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    rst   = 1'b1;
    for (int d = 0; d < 3; d++) begin
      rd[d] = 1'b0; wr[d] = 1'b0; be[d] = '0; ad[d] = '0; wd[d] = '0;
      last_rd[d] = '0;
      for (int i = 0; i < 1024; i++) begin
        mdl[d][i] = '0;
        vld[d][i] = 1'b0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_resp[%0d]", d), 32'(rsp[d]), 32'd0);
      check($sformatf("rst_rdata[%0d]", d), rdt[d], 32'd0);
`ifdef MEM_RESPONDER_CHECK_EN
      check($sformatf("rst_perr[%0d]", d), 32'(perr[d]), 32'd0);
`endif
    end
    rst = 1'b0;

    // Full write, read back, then masked write.
    txn(0, 1, 32'h100, 4'hF, 32'hDEADBEEF, 0, rc0);
    txn(0, 0, 32'h100, 4'h0, 32'h0, 0, rc0);
    check("full_word", rdt[0], 32'hDEADBEEF);
    txn(0, 1, 32'h100, 4'b0101, 32'h11223344, 0, rc0);
    txn(0, 0, 32'h100, 4'h0, 32'h0, 0, rc0);
    check("byte_mask", rdt[0], 32'hDE22BE44);
    // Zero byte-enable write completes and leaves storage alone.
    txn(0, 1, 32'h100, 4'h0, 32'hFFFFFFFF, 0, rc0);
    txn(0, 0, 32'h100, 4'h0, 32'h0, 0, rc0);

    // Back-to-back reads with the request held throughout.
    for (int d = 0; d < 2; d++) begin
      txn(d, 1, 32'h0, 4'hF, 32'hA0A0_0000 + 32'(d), 0, rc0);
      txn(d, 1, 32'h4, 4'hF, 32'hB1B1_0001 + 32'(d), 0, rc0);
      txn(d, 1, 32'h8, 4'hF, 32'hC2C2_0002 + 32'(d), 0, rc0);
      txn(d, 0, 32'h0, 4'h0, 32'h0, 1, rc0);
      txn(d, 0, 32'h4, 4'h0, 32'h0, 1, rc1);
      txn(d, 0, 32'h8, 4'h0, 32'h0, 0, rc2);
      check($sformatf("b2b_gap1[%0d]", d), 32'(rc1 - rc0), 32'(lat_of(d) + 1));
      check($sformatf("b2b_gap2[%0d]", d), 32'(rc2 - rc1), 32'(lat_of(d) + 1));
    end

    // Long-latency instance, including a write-then-read turnaround.
    txn(2, 1, 32'h10, 4'hF, 32'h5555AAAA, 1, rc0);
    txn(2, 0, 32'h10, 4'h0, 32'h0, 0, rc0);

    // Randomized traffic; upper address bits vary to exercise aliasing.
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < ((d == 2) ? 12 : 60); k++) begin
        idx = 32 + int'($urandom_range(0, 31));
        w   = ($urandom_range(0, 2) == 0) || !vld[d][idx];
        a   = ($urandom & 32'hFFFF_F003) | (32'(idx) << 2);
        b   = vld[d][idx] ? 4'($urandom_range(0, 15)) : 4'hF;
        txn(d, w, a, b, $urandom, 1'($urandom_range(0, 1)), rc0);
      end
      rd[d] = 1'b0;
      wr[d] = 1'b0;
    end

    // Reset during WAIT and during RESP of a write: neither commits.
    txn(0, 1, 32'h40, 4'hF, 32'h0, 0, rc0);
    reset_abort(32'h40, 32'hFFFFFFFF, 1);
    txn(0, 0, 32'h40, 4'h0, 32'h0, 0, rc0);
    check("rst_wait_no_commit", rdt[0], 32'h0);
    reset_abort(32'h40, 32'h12345678, 2);
    txn(0, 0, 32'h40, 4'h0, 32'h0, 0, rc0);
    check("rst_resp_no_commit", rdt[0], 32'h0);

    // Address change during WAIT: latched address is served.
    rd[0] = 1'b1;
    ad[0] = 32'h100;
    @(posedge clk); #1;
`ifdef MEM_RESPONDER_CHECK_EN
    check("perr_clean", 32'(perr[0]), 32'd0);
`endif
    ad[0] = 32'h4;
    @(posedge clk); #1;
    check("chg_resp", 32'(rsp[0]), 32'd1);
    check("chg_rdata", rdt[0], mdl[0][64]);
`ifdef MEM_RESPONDER_CHECK_EN
    check("perr_set", 32'(perr[0]), 32'd1);
`endif
    rd[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
`ifdef MEM_RESPONDER_CHECK_EN
    check("perr_sticky", 32'(perr[0]), 32'd1);
    check("perr_other1", 32'(perr[1]), 32'd0);
    check("perr_other2", 32'(perr[2]), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("perr_cleared", 32'(perr[0]), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
